// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, defaults and grant encoding for the writeback port arbiter.
package wb_port_arbiter_pkg;

  localparam int REG_BUS_WIDTH      = 32;
  localparam int REG_ADDR_BUS_WIDTH = 5;
  localparam int STARVE_MAX_DEFAULT = 4;
  localparam int AGE_W              = 4;

  typedef logic [REG_BUS_WIDTH-1:0]      reg_bus_t;
  typedef logic [REG_ADDR_BUS_WIDTH-1:0] reg_addr_bus_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_FIFO = 2'd2
  } grant_e;

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// Load-enable register and the 2-entry {addr, data} FIFO that buffers
// long-latency results until they win the regfile write port.
module dff_lr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= d;
  end

endmodule

module wb_arb_fifo2 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  output logic [1:0]        count,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic               wr_ptr;
  logic               rd_ptr;
  logic [ENTRY_W-1:0] entry [2];

  // NOTE: storage is reset too; only two entries, and it keeps the head
  // deterministic in waveforms after reset even though count gates its use.
  for (genvar i = 0; i < 2; i++) begin : g_entry
    dff_lr #(.W(ENTRY_W)) u_entry (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (push && (wr_ptr == 1'(i))),
      .d     ({push_addr, push_data}),
      .q     (entry[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign {head_addr, head_data} = entry[rd_ptr];

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between pipeline writeback and a buffered
// long-latency source. Optional macro: WB_ARB_X0_DROP_EN (suppress x0 writes).
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W     = REG_BUS_WIDTH,
  parameter int ADDR_W     = REG_ADDR_BUS_WIDTH,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_we_i,
  input  logic [ADDR_W-1:0] pipe_addr_i,
  input  logic [DATA_W-1:0] pipe_data_i,
  input  logic              lu_valid_i,
  input  logic [ADDR_W-1:0] lu_addr_i,
  input  logic [DATA_W-1:0] lu_data_i,
  output logic              lu_ready_o,
  output logic              rd_we_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              stall_o
);

  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_MAX);

  logic [1:0]       count;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [AGE_W-1:0] age;
  logic             fifo_nonempty;
  logic             force_drain;
  logic             push;
  logic             store;
  logic             pop;
  grant_e           grant;

  assign fifo_nonempty = (count != 2'd0);
  assign force_drain   = (age == AGE_MAX) && fifo_nonempty;
  assign lu_ready_o    = (count != 2'd2);
  assign push          = lu_valid_i && lu_ready_o;
`ifdef WB_ARB_X0_DROP_EN
  assign store = push && (lu_addr_i != '0);
`else
  assign store = push;
`endif
  assign pop = (grant == GNT_FIFO);

  wb_arb_fifo2 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (store),
    .pop       (pop),
    .push_addr (lu_addr_i),
    .push_data (lu_data_i),
    .count     (count),
    .head_addr (head_addr),
    .head_data (head_data)
  );

  // Reset also masks the port so a pipe write held across reset never leaks.
  always_comb begin
    grant = GNT_NONE;
    if (!rst_n)             grant = GNT_NONE;
    else if (force_drain)   grant = GNT_FIFO;
    else if (pipe_we_i)     grant = GNT_PIPE;
    else if (fifo_nonempty) grant = GNT_FIFO;
  end

  // NOTE: defaults first so no path through the case leaves an output latched.
  always_comb begin
    rd_we_o   = 1'b0;
    rd_addr_o = '0;
    rd_data_o = '0;
    unique case (grant)
      GNT_PIPE: begin
`ifdef WB_ARB_X0_DROP_EN
        if (pipe_addr_i != '0) begin
          rd_we_o   = 1'b1;
          rd_addr_o = pipe_addr_i;
          rd_data_o = pipe_data_i;
        end
`else
        rd_we_o   = 1'b1;
        rd_addr_o = pipe_addr_i;
        rd_data_o = pipe_data_i;
`endif
      end
      GNT_FIFO: begin
        rd_we_o   = 1'b1;
        rd_addr_o = head_addr;
        rd_data_o = head_data;
      end
      default: ;
    endcase
  end

  // A FIFO grant while the pipe wants to write only happens on a forced drain.
  assign stall_o = (grant == GNT_FIFO) && pipe_we_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    age <= '0;
    else if (!fifo_nonempty || pop) age <= '0;
    else if (age != AGE_MAX)       age <= age + 1'b1;
  end

endmodule
